btn_move_ctrl: RTL and testbench

BTN_MOVE_CTRL -- requirements
Module: btn_move_ctrl

---
 rtl/game2048_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/btn_move_ctrl.sv | 132 +++++++++++++
 tb/tb_btn_move_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared 2048 game constants: move directions and button FSM states.
// Also provides the press-priority helper used by btn_move_ctrl.
package game2048_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // ev bit order {R,L,D,U}; bit index equals the direction code.
  function automatic logic [1:0] pick_dir(input logic [3:0] ev);
    pick_dir = DIR_UP;
    priority case (1'b1)
      ev[0]:   pick_dir = DIR_UP;
      ev[1]:   pick_dir = DIR_DOWN;
      ev[2]:   pick_dir = DIR_LEFT;
      ev[3]:   pick_dir = DIR_RIGHT;
      default: pick_dir = DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer followed by a stability counter.
// Ports: clk, clr_n (sync active-low), btn_i raw level, level_o debounced.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [7:0] CMAX = 8'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_chk
    $error("DEBOUNCE_CYCLES out of range");
  end

  logic [1:0] sync_q;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       lvl_q, lvl_d;

  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    cnt_inc = cnt_q + 8'd1;
    if (sync_q[1] != lvl_q) begin
      if (cnt_inc == CMAX) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/btn_move_ctrl.sv
// Turns four debounced pushbuttons into valid/ready move commands.
// Ports: clk, clr_n (sync active-low), btnL/R/U/D raw levels,
// move_ready in; move_valid, move_dir out (registered).
// Optional BTN_AUTOREPEAT_EN: re-issue a held single direction.
module btn_move_ctrl
  import game2048_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_CYCLES   = 128
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir
);

  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_chk
    $error("REPEAT_CYCLES out of range");
  end

  // Bit order {R,L,D,U} so a bit index equals its direction code.
  logic [3:0] lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
    .clk(clk), .clr_n(clr_n), .btn_i(btnU), .level_o(lvl[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
    .clk(clk), .clr_n(clr_n), .btn_i(btnD), .level_o(lvl[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(clk), .clr_n(clr_n), .btn_i(btnL), .level_o(lvl[2])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .clr_n(clr_n), .btn_i(btnR), .level_o(lvl[3])
  );

  logic [3:0] prev_q, press_q;
  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       valid_q;

  // Press events are registered, adding the stage that sets the
  // DEBOUNCE_CYCLES+3 press-to-valid latency.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      prev_q  <= '0;
      press_q <= '0;
    end else begin
      prev_q  <= lvl;
      press_q <= lvl & ~prev_q;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [15:0] RMAX = 16'(REPEAT_CYCLES);

  logic [15:0] rep_q, rep_d, rep_inc;
  logic        rep_hit;

  // Runs only while the single held button is the latched one.
  always_comb begin
    rep_d   = '0;
    rep_hit = 1'b0;
    rep_inc = rep_q + 16'd1;
    if (state_q == ST_HOLD && lvl == (4'b0001 << dir_q)) begin
      if (rep_inc == RMAX) begin
        rep_hit = 1'b1;
      end else begin
        rep_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|press_q) begin
          state_d = ST_PEND;
          dir_d   = pick_dir(press_q);
        end
      end
      ST_PEND: begin
        if (valid_q && move_ready) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (lvl == 4'b0000) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_hit) begin
          state_d = ST_PEND;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      valid_q <= (state_d == ST_PEND);
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Self-checking bench for btn_move_ctrl: directed scenarios plus random
// button traffic compared against a cycle reference model.
module tb_btn_move_ctrl;

  localparam int N = 8;
  localparam int R = 16;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;

  btn_move_ctrl #(.DEBOUNCE_CYCLES(N), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .clr_n(clr_n),
    .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
    .move_ready(move_ready),
    .move_valid(move_valid), .move_dir(move_dir)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int dut_xfer = 0;
  int vq[$];
  int dq[$];

  // Reference model, index 0 U, 1 D, 2 L, 3 R.
  int m_s1[4], m_s2[4], m_lvl[4], m_run[4], m_prv[4], m_prs[4];
  int m_mode;  // 0 idle, 1 offering, 2 waiting for release
  int m_dir, m_rep;

  task automatic chk(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Updated stage by stage from the back so each uses pre-edge values.
  task automatic model_edge();
    int raw[4];
    int held, first;
    raw[0] = int'(btnU); raw[1] = int'(btnD);
    raw[2] = int'(btnL); raw[3] = int'(btnR);
    if (!clr_n) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
        m_run[i] = 0; m_prv[i] = 0; m_prs[i] = 0;
      end
      m_mode = 0; m_dir = 0; m_rep = 0;
    end else begin
      held = 0; first = -1;
      for (int i = 0; i < 4; i++) begin
        held += m_lvl[i];
        if (m_prs[i] != 0 && first < 0) first = i;
      end
      if (m_mode == 0) begin
        m_rep = 0;
        if (first >= 0) begin m_mode = 1; m_dir = first; end
      end else if (m_mode == 1) begin
        m_rep = 0;
        if (move_ready) m_mode = 2;
      end else begin
        if (held == 0) begin
          m_mode = 0; m_rep = 0;
        end else if (AR && held == 1 && m_lvl[m_dir] == 1) begin
          m_rep++;
          if (m_rep == R) begin m_mode = 1; m_rep = 0; end
        end else begin
          m_rep = 0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_prs[i] = (m_lvl[i] == 1 && m_prv[i] == 0) ? 1 : 0;
        m_prv[i] = m_lvl[i];
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin m_lvl[i] = m_s2[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  endtask

  task automatic tick();
    if (move_valid && move_ready && clr_n) dut_xfer++;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", int'(move_valid), (m_mode == 1) ? 1 : 0);
    chk("dir", int'(move_dir), m_dir);
    if (move_valid) begin
      vq.push_back(edge_n);
      dq.push_back(int'(move_dir));
    end
    edge_n++;
  endtask

  task automatic clear_log();
    vq.delete();
    dq.delete();
    edge_n = 0;
    dut_xfer = 0;
  endtask

  initial begin
    int hl[4];
    logic [3:0] lv;
    int bad;

    // Reset and first press of L with ready high.
    repeat (2) tick();
    chk("rst_valid", int'(move_valid), 0);
    chk("rst_dir", int'(move_dir), 0);
    clr_n = 1'b1; btnL = 1'b1; move_ready = 1'b1;
    clear_log();
    repeat (26) tick();
    chk("s1_count", vq.size(), 1);
    chk("s1_edge", vq[0], 11);
    chk("s1_dir", dq[0], 2);
    btnL = 1'b0;
    clear_log();
    repeat (25) tick();
    chk("s1_release", vq.size(), 0);
    btnL = 1'b1;
    clear_log();
    repeat (25) tick();
    chk("s1_repress", vq.size(), 1);
    chk("s1_reedge", vq[0], 11);
    btnL = 1'b0;
    repeat (25) tick();

    // Short glitch on U.
    clear_log();
    btnU = 1'b1;
    repeat (5) tick();
    btnU = 1'b0;
    repeat (25) tick();
    chk("s2_glitch", vq.size(), 0);

    // D and R together: D wins.
    clear_log();
    btnD = 1'b1; btnR = 1'b1;
    repeat (25) tick();
    chk("s3_count", vq.size(), 1);
    chk("s3_dir", dq[0], 1);
    btnD = 1'b0; btnR = 1'b0;
    repeat (25) tick();

    // R stalled by ready low; U pressed meanwhile is lost.
    move_ready = 1'b0;
    btnR = 1'b1;
    clear_log();
    repeat (5) tick();
    btnU = 1'b1;
    repeat (15) tick();
    chk("s4_pend_valid", int'(move_valid), 1);
    chk("s4_pend_dir", int'(move_dir), 3);
    move_ready = 1'b1;
    repeat (5) tick();
    btnR = 1'b0; btnU = 1'b0;
    repeat (25) tick();
    chk("s4_cycles", vq.size(), 9);
    bad = 0;
    foreach (dq[i]) if (dq[i] != 3) bad++;
    chk("s4_dir_stable", bad, 0);
    chk("s4_xfer", dut_xfer, 1);

    // Reset while offering, button still held.
    move_ready = 1'b0;
    btnL = 1'b1;
    repeat (12) tick();
    chk("s5_pend", int'(move_valid), 1);
    clr_n = 1'b0;
    tick();
    chk("s5_rst_valid", int'(move_valid), 0);
    chk("s5_rst_dir", int'(move_dir), 0);
    clr_n = 1'b1; move_ready = 1'b1;
    clear_log();
    repeat (20) tick();
    chk("s5_count", vq.size(), 1);
    chk("s5_edge", vq[0], 11);
    chk("s5_dir", dq[0], 2);
    btnL = 1'b0;
    repeat (25) tick();

    // Long hold of U.
    btnU = 1'b1;
    clear_log();
    repeat (60) tick();
    chk("s6_count", vq.size(), AR ? 3 : 1);
    chk("s6_first", vq[0], 11);
    chk("s6_dir", dq[0], 0);
    if (vq.size() >= 2) chk("s6_gap", vq[1] - vq[0], 17);
    chk("s6_xfer", dut_xfer, AR ? 3 : 1);
    btnU = 1'b0;
    repeat (25) tick();

    // Random traffic with held levels, bounces and rare resets.
    for (int i = 0; i < 4; i++) hl[i] = 0;
    lv = '0;
    repeat (800) begin
      for (int i = 0; i < 4; i++) begin
        if (hl[i] == 0) begin
          lv[i] = ($urandom_range(0, 2) == 0);
          hl[i] = $urandom_range(1, 30);
        end else begin
          hl[i]--;
        end
      end
      {btnR, btnL, btnD, btnU} = lv;
      move_ready = ($urandom_range(0, 3) != 0);
      clr_n = ($urandom_range(0, 249) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
